// File: rtl/wb2axi4l_bridge.sv
// Wishbone B3 classic slave to AXI4-Lite master bridge.
// One outstanding transaction; registered outputs; response timeout.
module wb2axi4l_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [2:0]  AXI_PROT       = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t      state;
  logic [31:0] tmo_cnt;
  logic        req;
  logic        aw_ok;
  logic        w_ok;
  logic        tmo_hit;

  assign m_axi_awprot = AXI_PROT;
  assign m_axi_arprot = AXI_PROT;

  // ack/err gating stops re-accepting the strobe still held in the ack cycle
  assign req   = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign aw_ok = ~m_axi_awvalid | m_axi_awready;
  assign w_ok  = ~m_axi_wvalid | m_axi_wready;

  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   (tmo_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      wb_dat_o      <= '0;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            m_axi_awaddr <= wb_adr_i;
            m_axi_araddr <= wb_adr_i;
            m_axi_wdata  <= wb_dat_i;
            m_axi_wstrb  <= wb_sel_i;
            if (wb_we_i) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_ADDR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axi_bready <= 1'b1;
            tmo_cnt      <= '0;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            wb_ack_o     <= wb_cyc_i & ~m_axi_bresp[1];
            wb_err_o     <= wb_cyc_i & m_axi_bresp[1];
            state        <= IDLE;
          end else if (tmo_hit) begin
            m_axi_bready <= 1'b0;
            wb_err_o     <= wb_cyc_i;
            state        <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            tmo_cnt       <= '0;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            wb_dat_o     <= m_axi_rdata;
            wb_ack_o     <= wb_cyc_i & ~m_axi_rresp[1];
            wb_err_o     <= wb_cyc_i & m_axi_rresp[1];
            state        <= IDLE;
          end else if (tmo_hit) begin
            m_axi_rready <= 1'b0;
            wb_err_o     <= wb_cyc_i;
            state        <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb2axi4l_bridge.sv
// Bench for wb2axi4l_bridge: randomized AXI slave timing,
// scoreboard of expected Wishbone completions.
module tb_wb2axi4l_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  wb2axi4l_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          err;
    logic [31:0] dat;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        q_exp[$];
  logic [31:0] q_aw[$];
  logic [35:0] q_w[$];
  logic [31:0] q_ar[$];
  logic [31:0] last_rd;

  // slave configuration for the current transaction
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  bit          b_never;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;

  // ---------------- AXI4-Lite slave model ----------------
  bit aw_got, w_got, ar_got;
  bit h_aw, h_w, h_b, h_ar, h_r, r_rst;
  logic [31:0] tmp32;
  logic [35:0] tmp36;
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    forever begin
      @(negedge clk);
      r_rst = rst;
      h_aw = awvalid && awready;
      h_w  = wvalid && wready;
      h_b  = bvalid && bready;
      h_ar = arvalid && arready;
      h_r  = rvalid && rready;
      if (!r_rst && h_aw) begin
        if (q_aw.size() == 0) chk("aw_unexpected", awaddr, 32'hx);
        else begin
          tmp32 = q_aw.pop_front();
          chk("awaddr", awaddr, tmp32);
          chk("awprot", {29'b0, awprot}, 0);
        end
      end
      if (!r_rst && h_w) begin
        if (q_w.size() == 0) chk("w_unexpected", wdata, 32'hx);
        else begin
          tmp36 = q_w.pop_front();
          chk("wdata", wdata, tmp36[31:0]);
          chk("wstrb", {28'b0, wstrb}, {28'b0, tmp36[35:32]});
        end
      end
      if (!r_rst && h_ar) begin
        if (q_ar.size() == 0) chk("ar_unexpected", araddr, 32'hx);
        else begin
          tmp32 = q_ar.pop_front();
          chk("araddr", araddr, tmp32);
          chk("arprot", {29'b0, arprot}, 0);
        end
      end
      @(posedge clk);
      #1;
      if (r_rst) begin
        awready = 0; wready = 0; bvalid = 0;
        arready = 0; rvalid = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
      end else begin
        if (h_aw) begin awready = 0; aw_got = 1; end
        else if (awvalid && !aw_got) begin
          if (aw_wait == 0) awready = 1; else aw_wait--;
        end
        if (h_w) begin wready = 0; w_got = 1; end
        else if (wvalid && !w_got) begin
          if (w_wait == 0) wready = 1; else w_wait--;
        end
        if (h_b) begin bvalid = 0; aw_got = 0; w_got = 0; end
        else if (aw_got && w_got && !bvalid) begin
          if (b_never) begin aw_got = 0; w_got = 0; end
          else if (b_wait == 0) begin bvalid = 1; bresp = cfg_bresp; end
          else b_wait--;
        end
        if (h_ar) begin arready = 0; ar_got = 1; end
        else if (arvalid && !ar_got) begin
          if (ar_wait == 0) arready = 1; else ar_wait--;
        end
        if (h_r) begin rvalid = 0; ar_got = 0; end
        else if (ar_got && !rvalid) begin
          if (r_wait == 0) begin
            rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp;
          end else r_wait--;
        end
      end
    end
  end

  // ---------------- completion monitor ----------------
  exp_t e_mon;
  bit   prev_done = 0;
  bit   p_rst = 1;
  bit   p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_araddr;
  int   blen_run = 0;
  int   last_blen = 0;
  always @(negedge clk) begin
    if (wb_ack_o || wb_err_o) begin
      chk("pulse_width", {31'b0, prev_done}, 0);
      chk("ack_err_excl", {31'b0, wb_ack_o & wb_err_o}, 0);
      if (q_exp.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: ack=%b err=%b want none",
                 wb_ack_o, wb_err_o);
      end else begin
        e_mon = q_exp.pop_front();
        chk("resp_err", {31'b0, wb_err_o}, {31'b0, e_mon.err});
        chk("resp_ack", {31'b0, wb_ack_o}, {31'b0, !e_mon.err});
        chk("wb_dat_o", wb_dat_o, e_mon.dat);
        if (e_mon.lat >= 0)
          chk("latency", cyc_cnt - e_mon.t0, e_mon.lat);
      end
    end
    prev_done = wb_ack_o || wb_err_o;
    if (!p_rst && !rst) begin
      if (p_awv && !p_awr) begin
        chk("awvalid_hold", {31'b0, awvalid}, 1);
        chk("awaddr_hold", awaddr, p_awaddr);
      end
      if (p_wv && !p_wr) chk("wvalid_hold", {31'b0, wvalid}, 1);
      if (p_arv && !p_arr) begin
        chk("arvalid_hold", {31'b0, arvalid}, 1);
        chk("araddr_hold", araddr, p_araddr);
      end
    end
    p_rst = rst;
    p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
    p_wv = wvalid; p_wr = wready;
    p_arv = arvalid; p_arr = arready; p_araddr = araddr;
    if (bready) blen_run++;
    else if (blen_run != 0) begin last_blen = blen_run; blen_run = 0; end
  end

  // ---------------- stimulus ----------------
  task automatic set_slv(input int aw, input int w, input int b,
                         input int ar, input int r,
                         input logic [1:0] br, input logic [1:0] rr,
                         input logic [31:0] rd);
    aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
    cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd;
  endtask

  // reference model: a write returns bresp class (or err on timeout) and
  // leaves read data untouched; a read always updates the read data
  task automatic xfer(input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int lat);
    exp_t e;
    bit   done;
    if (w) begin
      q_aw.push_back(a);
      q_w.push_back({s, d});
      e.err = b_never ? 1'b1 : cfg_bresp[1];
      e.dat = last_rd;
    end else begin
      q_ar.push_back(a);
      e.err = cfg_rresp[1];
      e.dat = cfg_rdata;
      last_rd = cfg_rdata;
    end
    e.lat = lat;
    e.t0  = cyc_cnt;
    q_exp.push_back(e);
    adr = a; dat = d; sel = s; we = w; cyc = 1; stb = 1;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = wb_ack_o || wb_err_o;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL xfer_wait: no ack/err in 100 cycles adr=%h", a);
      q_exp.delete();
    end
    @(posedge clk);
    #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    rst = 1; cyc = 0; stb = 0; we = 0;
    adr = 0; dat = 0; sel = 0;
    b_never = 0; last_rd = 0;
    set_slv(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_awvalid", {31'b0, awvalid}, 0);
    chk("rst_wvalid", {31'b0, wvalid}, 0);
    chk("rst_bready", {31'b0, bready}, 0);
    chk("rst_arvalid", {31'b0, arvalid}, 0);
    chk("rst_rready", {31'b0, rready}, 0);
    chk("rst_ack", {31'b0, wb_ack_o}, 0);
    chk("rst_err", {31'b0, wb_err_o}, 0);
    chk("rst_dat", wb_dat_o, 0);
    @(posedge clk);
    #1;

    // always-ready write, minimum latency
    set_slv(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    xfer(1, 32'h0000_0040, 32'h1234_5678, 4'hF, 3);
    // delayed arready and rvalid
    set_slv(0, 0, 0, 4, 2, 2'b00, 2'b00, 32'hDEAD_BEEF);
    xfer(0, 32'h0000_0044, 32'h0, 4'hF, -1);
    // wready three cycles ahead of awready
    set_slv(3, 0, 0, 0, 0, 2'b01, 2'b00, 32'h0);
    xfer(1, 32'h0000_0048, 32'hA5A5_0001, 4'b0011, -1);
    // SLVERR read then DECERR write
    set_slv(0, 0, 0, 0, 1, 2'b00, 2'b10, 32'h0000_BAD0);
    xfer(0, 32'h0000_004C, 32'h0, 4'hF, -1);
    set_slv(0, 0, 0, 0, 0, 2'b11, 2'b00, 32'h0);
    xfer(1, 32'h0000_0050, 32'hCAFE_F00D, 4'hC, -1);

    // response timeout
    b_never = 1;
    set_slv(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    xfer(1, 32'h0000_0054, 32'h1111_2222, 4'hF, -1);
    chk("tmo_bready_len", last_blen, 8);
    b_never = 0;
    set_slv(1, 2, 0, 1, 1, 2'b00, 2'b00, 32'h7654_3210);
    xfer(0, 32'h0000_0058, 32'h0, 4'hF, -1);

    // abandoned write: AXI side completes, no Wishbone pulse
    set_slv(3, 1, 1, 0, 0, 2'b00, 2'b00, 32'h0);
    q_aw.push_back(32'h0000_0060);
    q_w.push_back({4'h5, 32'h0BAD_CAFE});
    adr = 32'h0000_0060; dat = 32'h0BAD_CAFE; sel = 4'h5;
    we = 1; cyc = 1; stb = 1;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0; stb = 0; we = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("abandon_aw_done", q_aw.size(), 0);
    chk("abandon_w_done", q_w.size(), 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      set_slv($urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom);
      xfer(w, $urandom, $urandom, 4'($urandom_range(0, 15)), -1);
    end

    // reset while waiting in the read data phase
    set_slv(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0F0F_0F0F);
    xfer(0, 32'h0000_0070, 32'h0, 4'hF, -1);
    set_slv(0, 0, 0, 0, 6, 2'b00, 2'b00, 32'h5555_AAAA);
    q_ar.push_back(32'h0000_0074);
    adr = 32'h0000_0074; we = 0; cyc = 1; stb = 1;
    for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
    chk("rst_reach_rd_data", {31'b0, rready}, 1);
    @(posedge clk);
    #1;
    rst = 1; cyc = 0; stb = 0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_awvalid", {31'b0, awvalid}, 0);
    chk("mid_rst_wvalid", {31'b0, wvalid}, 0);
    chk("mid_rst_bready", {31'b0, bready}, 0);
    chk("mid_rst_arvalid", {31'b0, arvalid}, 0);
    chk("mid_rst_rready", {31'b0, rready}, 0);
    chk("mid_rst_ack", {31'b0, wb_ack_o}, 0);
    chk("mid_rst_err", {31'b0, wb_err_o}, 0);
    chk("mid_rst_dat", wb_dat_o, 0);
    last_rd = 0;
    @(posedge clk);
    #1;
    set_slv(0, 0, 0, 2, 0, 2'b00, 2'b01, 32'h3C3C_C3C3);
    xfer(0, 32'h0000_0078, 32'h0, 4'hF, -1);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", q_exp.size(), 0);
    chk("aw_queue_drained", q_aw.size(), 0);
    chk("ar_queue_drained", q_ar.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb2axi4l_bridge.md
Name: wb2axi4l_bridge

Overview:
- Wishbone classic (B3, non-pipelined) slave to AXI4-Lite master bridge; the reverse direction of the AXI4-Lite-to-Wishbone bridge used in front of the DSP/crypto cores.
- Lets a Wishbone-based initiator (test/debug master, legacy DMA) reach AXI4-Lite slaves on the CEP interconnect.
- Exactly one outstanding transaction. Captures the Wishbone request, runs one AXI4-Lite read or write, and returns a single-cycle ack or err.

Parameters:
- ADDR_WIDTH, 32: Wishbone and AXI address width.
- DATA_WIDTH, 32: data width; only 32 supported, so strobes are 4 bits.
- AXI_PROT, 3'b000: constant driven on awprot/arprot.
- TIMEOUT_CYCLES, 1024: response-phase timeout in cycles; 0 disables it.

Ports:
- wb_clk_i  in  1  clock, all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- wb_adr_i  in  ADDR_WIDTH  byte address
- wb_dat_i  in  DATA_WIDTH  write data
- wb_sel_i  in  4  byte selects
- wb_we_i  in  1  1 = write
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_dat_o  out  DATA_WIDTH  read data
- wb_ack_o  out  1  normal completion pulse
- wb_err_o  out  1  error completion pulse
- m_axi_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  write address channel
- m_axi_awready  in  1
- m_axi_wdata/wstrb/wvalid  out  DATA_WIDTH/4/1  write data channel
- m_axi_wready  in  1
- m_axi_bresp/bvalid  in  2/1  write response
- m_axi_bready  out  1
- m_axi_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  read address channel
- m_axi_arready  in  1
- m_axi_rdata/rresp/rvalid  in  DATA_WIDTH/2/1  read data
- m_axi_rready  out  1

Behaviour:
- Reset (sync, wb_rst_i=1 at edge):
  - State to IDLE.
  - All valids/readies, wb_ack_o, wb_err_o and the timeout counter to 0; wb_dat_o to 0.
  - Reset mid-transaction aborts immediately; the AXI slave shares this reset.
- All outputs are registered.
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - Accepts when wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o. This blocks re-accepting the stb still high during the ack cycle.
  - Latches address, data, sel and we.
  - Write: goes to WR_ADDR and asserts awvalid and wvalid together.
  - Read: goes to RD_ADDR and asserts arvalid.
  - awaddr/araddr = latched wb_adr_i unmodified; wstrb = latched wb_sel_i (sel=0 still issued).
- WR_ADDR:
  - awvalid drops the cycle after awready is sampled high; wvalid drops the cycle after wready is sampled high. The two are tracked independently, in any order, including the same cycle.
  - Once both handshakes have completed, goes to WR_RESP with bready=1.
  - Valids are never withdrawn before ready (AXI rule); there is no timeout here.
- WR_RESP: on bvalid&bready, bready drops and state goes to IDLE.
  - bresp 00/01 (OKAY/EXOKAY) gives a wb_ack_o pulse next cycle.
  - bresp 10/11 gives a wb_err_o pulse.
- RD_ADDR: on arvalid&arready, arvalid drops and state goes to RD_DATA with rready=1.
- RD_DATA: on rvalid&rready, wb_dat_o <= rdata (also on error responses), rready drops, state goes to IDLE, and ack/err is decided by rresp as for writes.
- wb_dat_o holds its value until the next read completes.
- Latency with an always-ready slave that responds immediately: request sampled at edge 0, valids high in cycle 1, ready high in cycle 2, ack high in cycle 3. Minimum is 3 cycles from request sample to ack.
- ack and err are exactly one cycle wide and mutually exclusive.
- Timeout:
  - The counter runs only in WR_RESP/RD_DATA and clears on entry.
  - If it reaches TIMEOUT_CYCLES with no bvalid/rvalid: drop bready/rready, pulse wb_err_o, go to IDLE, leave wb_dat_o unchanged.
  - A response arriving in the same cycle as the timeout wins; it completes normally.
- Abandoned cycle: if wb_cyc_i drops mid-transaction, the AXI transaction still runs to completion. The ack/err pulse is suppressed if wb_cyc_i=0 in the completion cycle.
- No pipelining; a new request is accepted no earlier than the cycle after the ack/err pulse.

Test Plan:
- Write 0x1234_5678 to 0x0000_0040 with sel=4'hF; slave always ready, bresp=00 -> awaddr=0x40, wdata=0x12345678, wstrb=F; wb_ack_o high exactly one cycle, 3 cycles after request; no err.
- Read 0x0000_0044; slave returns rdata=0xDEAD_BEEF with arready delayed 4 cycles and rvalid 2 further cycles -> arvalid held steady until arready; wb_dat_o=0xDEADBEEF with the ack pulse.
- Write where wready precedes awready by 3 cycles, sel=4'b0011 -> each valid drops independently after its handshake; wstrb=3; single ack.
- Read with rresp=10 (SLVERR), rdata=0xBAD0 -> wb_err_o pulse, no ack, wb_dat_o=0xBAD0; back-to-back write with bresp=11 -> err.
- TIMEOUT_CYCLES=8, slave never asserts bvalid -> bready high 8 cycles, then drops; wb_err_o pulse; next read accepted and completes normally.
- Assert wb_rst_i in RD_DATA -> next cycle all valid/ready, ack and err are 0 and wb_dat_o=0; a request held with stb high during the ack cycle is not accepted twice.
